cholesky_scheduler: RTL and testbench

CHOLESKY_SCHEDULER -- requirements
Module: cholesky_scheduler

---
 rtl/cholesky_scheduler_pkg.sv | 30 +++
 rtl/rr_arbiter2.sv | 35 +++
 rtl/cholesky_scheduler.sv | 154 +++++++++++++++
 tb/tb_cholesky_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cholesky_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cholesky_scheduler_pkg
// Description : Shared types and helpers for the two-requester Cholesky
//               job scheduler: FSM states, element packing, zero constant.
// Revision    : 1.0 - initial release
// ============================================================================
package cholesky_scheduler_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Width of one IEEE-754 double matrix element
  localparam int C_ELEM_W = 64;

  // One all-zero element; replicated SIZE*SIZE times to form a zero factor
  localparam logic [C_ELEM_W-1:0] C_ZERO_ELEM = '0;

  // Bit offset of element (i,j) in a row-major packed SIZE x SIZE matrix
  function automatic int elem_lsb(input int size, input int i, input int j);
    return (i * size + j) * C_ELEM_W;
  endfunction

endpackage : cholesky_scheduler_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin grant logic. The pointer names the
//               preferred requester; after a grant it moves to the other one.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  input  logic       update_i,
  output logic [1:0] grant_o,
  output logic       ptr_next_o
);

  // Pick a winner only when a grant is allowed; pointer goes to the loser
  always_comb begin
    grant_o    = 2'b00;
    ptr_next_o = ptr_i;
    if (update_i) begin
      if (req_i == 2'b11) begin
        grant_o = ptr_i ? 2'b10 : 2'b01;
      end else begin
        grant_o = req_i;
      end
      if (grant_o[0]) begin
        ptr_next_o = 1'b1;
      end else if (grant_o[1]) begin
        ptr_next_o = 1'b0;
      end
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/cholesky_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cholesky_scheduler
// Description : Shares one Cholesky unit between two requesters. Grants a
//               job round-robin, strobes the unit, waits for a ready edge or
//               a timeout, then returns the factor to the owning requester.
// Revision    : 1.0 - initial release
// ============================================================================
module cholesky_scheduler
  import cholesky_scheduler_pkg::*;
#(
  parameter int  SIZE      = 3,
  parameter int  EN_CYCLES = 3,
  parameter int  TIMEOUT   = 4096,
  localparam int W         = SIZE * SIZE * C_ELEM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid_i,
  input  logic [W-1:0] req_matrix0_i,
  input  logic [W-1:0] req_matrix1_i,
  output logic [1:0]   req_accept_o,
  output logic [1:0]   resp_valid_o,
  output logic [W-1:0] resp_factor_o,
  output logic         resp_error_o,
  output logic         busy_o,
  output logic [W-1:0] chol_matrix_o,
  output logic         chol_enable_o,
  input  logic [W-1:0] chol_factor_i,
  input  logic         chol_ready_i
);

  localparam int C_EN_W = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
  localparam int C_TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [C_EN_W-1:0] C_EN_LAST   = C_EN_W'(EN_CYCLES - 1);
  localparam logic [C_TO_W-1:0] C_TO_LAST   = C_TO_W'(TIMEOUT - 1);
  localparam logic [W-1:0]      C_ZERO_FACT = {(SIZE * SIZE){C_ZERO_ELEM}};

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic [1:0]          owner_q, owner_d;
  logic [C_EN_W-1:0]   en_cnt_q, en_cnt_d;
  logic [C_TO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                ready_q;
  logic [W-1:0]        chol_matrix_q, chol_matrix_d;
  logic [W-1:0]        resp_factor_q, resp_factor_d;
  logic                resp_error_q, resp_error_d;

  logic                w_arb_update;
  logic [1:0]          w_grant;
  logic                w_ptr_next;
  logic                w_ready_rise;

  // Grants are only offered while idle and out of reset
  assign w_arb_update = (state_q == ST_IDLE) && rst;

  // Completion is a low-to-high change relative to last cycle's sample
  assign w_ready_rise = chol_ready_i && !ready_q;

  rr_arbiter2 u_arb (
    .req_i      (req_valid_i),
    .ptr_i      (ptr_q),
    .update_i   (w_arb_update),
    .grant_o    (w_grant),
    .ptr_next_o (w_ptr_next)
  );

  // Next-state and datapath update decisions for the job FSM
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    en_cnt_d      = en_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    chol_matrix_d = chol_matrix_q;
    resp_factor_d = resp_factor_q;
    resp_error_d  = resp_error_q;
    case (state_q)
      ST_IDLE: begin
        if (w_grant != 2'b00) begin
          state_d       = ST_START;
          ptr_d         = w_ptr_next;
          owner_d       = w_grant;
          en_cnt_d      = '0;
          chol_matrix_d = w_grant[1] ? req_matrix1_i : req_matrix0_i;
        end
      end
      ST_START: begin
        if (en_cnt_q == C_EN_LAST) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end else begin
          en_cnt_d = en_cnt_q + C_EN_W'(1);
        end
      end
      ST_WAIT: begin
        // A ready edge takes priority over a simultaneous timeout
        if (w_ready_rise) begin
          state_d       = ST_RESP;
          resp_factor_d = chol_factor_i;
          resp_error_d  = 1'b0;
        end else if (wait_cnt_q == C_TO_LAST) begin
          state_d       = ST_RESP;
          resp_factor_d = C_ZERO_FACT;
          resp_error_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + C_TO_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= 1'b0;
      owner_q       <= 2'b00;
      en_cnt_q      <= '0;
      wait_cnt_q    <= '0;
      ready_q       <= 1'b0;
      chol_matrix_q <= '0;
      resp_factor_q <= '0;
      resp_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      en_cnt_q      <= en_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      ready_q       <= chol_ready_i;
      chol_matrix_q <= chol_matrix_d;
      resp_factor_q <= resp_factor_d;
      resp_error_q  <= resp_error_d;
    end
  end

  // Strobes are gated by reset so an abandoned job releases them at once
  assign req_accept_o  = w_grant;
  assign chol_enable_o = (state_q == ST_START) && rst;
  assign resp_valid_o  = ((state_q == ST_RESP) && rst) ? owner_q : 2'b00;
  assign busy_o        = (state_q != ST_IDLE);
  assign resp_factor_o = resp_factor_q;
  assign resp_error_o  = resp_error_q;
  assign chol_matrix_o = chol_matrix_q;

endmodule : cholesky_scheduler
`default_nettype wire

// File: tb/tb_cholesky_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cholesky_scheduler
// Description : Self-checking bench for cholesky_scheduler with a behavioural
//               Cholesky unit and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cholesky_scheduler;
  import cholesky_scheduler_pkg::*;

  localparam int SIZE      = 3;
  localparam int EN_CYCLES = 3;
  localparam int TIMEOUT   = 16;
  localparam int MODEL_LAT = 3;
  localparam int W         = SIZE * SIZE * C_ELEM_W;

  typedef struct packed {
    logic [1:0]   who;
    logic         err;
    logic [W-1:0] factor;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid_i;
  logic [W-1:0] req_matrix0_i, req_matrix1_i;
  logic [1:0]   req_accept_o, resp_valid_o;
  logic [W-1:0] resp_factor_o, chol_matrix_o, chol_factor_i;
  logic         resp_error_o, busy_o, chol_enable_o, chol_ready_i;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   en_hi    = 0;
  int   model_mode = 0;  // 0: auto-complete, 1: never complete, 2: driven by test
  exp_t sb[$];

  cholesky_scheduler #(.SIZE(SIZE), .EN_CYCLES(EN_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_matrix0_i (req_matrix0_i),
    .req_matrix1_i (req_matrix1_i),
    .req_accept_o  (req_accept_o),
    .resp_valid_o  (resp_valid_o),
    .resp_factor_o (resp_factor_o),
    .resp_error_o  (resp_error_o),
    .busy_o        (busy_o),
    .chol_matrix_o (chol_matrix_o),
    .chol_enable_o (chol_enable_o),
    .chol_factor_i (chol_factor_i),
    .chol_ready_i  (chol_ready_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (chol_enable_o === 1'b1) en_hi++;

  function automatic logic [W-1:0] mat3(input int a, b, c, d, e, f, g, h, k);
    int v[9];
    logic [W-1:0] r;
    v = '{a, b, c, d, e, f, g, h, k};
    for (int n = 0; n < 9; n++) r[n*64 +: 64] = $realtobits(real'(v[n]));
    return r;
  endfunction

  function automatic logic [W-1:0] chol_ref(input logic [W-1:0] a);
    real l [SIZE][SIZE];
    real s;
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) l[i][j] = 0.0;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j <= i; j++) begin
        s = $bitstoreal(a[elem_lsb(SIZE, i, j) +: 64]);
        for (int k = 0; k < j; k++) s = s - l[i][k] * l[j][k];
        l[i][j] = (i == j) ? $sqrt(s) : s / l[j][j];
        r[elem_lsb(SIZE, i, j) +: 64] = $realtobits(l[i][j]);
      end
    end
    return r;
  endfunction

  // Behavioural Cholesky unit: factor appears MODEL_LAT cycles after enable drops
  bit           m_seen = 1'b0;
  int           m_cnt  = 0;
  logic [W-1:0] m_fact;
  always @(negedge clk) begin
    if (model_mode == 0) begin
      if (chol_enable_o === 1'b1 && !m_seen) begin
        m_seen = 1'b1; m_cnt = 0; chol_ready_i = 1'b0;
        m_fact = chol_ref(chol_matrix_o);
      end else if (chol_enable_o === 1'b0 && m_seen) begin
        m_cnt++;
        if (m_cnt == MODEL_LAT) begin
          chol_ready_i = 1'b1; chol_factor_i = m_fact; m_seen = 1'b0;
        end
      end
    end else if (model_mode == 1) begin
      m_seen = 1'b0;
      if (chol_enable_o === 1'b1) chol_ready_i = 1'b0;
    end
  end

  task automatic wait_accept(output logic [1:0] acc, output int at);
    acc = 2'b00; at = -1;
    repeat (100) begin
      @(negedge clk);
      if (req_accept_o !== 2'b00) begin acc = req_accept_o; at = cyc; return; end
    end
  endtask

  task automatic wait_resp(output logic [1:0] rv, output logic err,
                           output logic [W-1:0] f, output int at);
    rv = 2'b00; err = 1'b0; f = '0; at = -1;
    repeat (100) begin
      @(negedge clk);
      if (resp_valid_o !== 2'b00) begin
        rv = resp_valid_o; err = resp_error_o; f = resp_factor_o; at = cyc; return;
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0; req_valid_i = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
    n_checks++; if (chol_enable_o !== 1'b0) $display("FAIL reset_enable: got %b want 0", chol_enable_o); else n_pass++;
    n_checks++; if (req_accept_o !== 2'b00) $display("FAIL reset_accept: got %b want 00", req_accept_o); else n_pass++;
    n_checks++; if (resp_valid_o !== 2'b00) $display("FAIL reset_resp_valid: got %b want 00", resp_valid_o); else n_pass++;
    n_checks++; if (resp_error_o !== 1'b0) $display("FAIL reset_resp_error: got %b want 0", resp_error_o); else n_pass++;
    n_checks++; if (resp_factor_o !== '0) $display("FAIL reset_resp_factor: got %h want 0", resp_factor_o); else n_pass++;
    n_checks++; if (chol_matrix_o !== '0) $display("FAIL reset_chol_matrix: got %h want 0", chol_matrix_o); else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_single();
    logic [W-1:0] m, f;
    logic [1:0] acc, rv;
    logic err;
    int at_a, at_r;
    exp_t e;
    m = mat3(25, 15, -5, 15, 18, 0, -5, 0, 11);
    model_mode = 0;
    @(posedge clk); #1;
    req_matrix0_i = m;
    e.who = 2'b01; e.err = 1'b0; e.factor = chol_ref(m); sb.push_back(e);
    en_hi = 0; req_valid_i = 2'b01;
    wait_accept(acc, at_a);
    n_checks++; if (acc !== 2'b01) $display("FAIL single_accept: got %b want 01", acc); else n_pass++;
    @(posedge clk); #1 req_valid_i = 2'b00;
    n_checks++; if (chol_matrix_o !== m) $display("FAIL single_chol_matrix: got %h want %h", chol_matrix_o, m); else n_pass++;
    wait_resp(rv, err, f, at_r);
    e = sb.pop_front();
    n_checks++; if (rv !== e.who) $display("FAIL single_resp_valid: got %b want %b", rv, e.who); else n_pass++;
    n_checks++; if (err !== e.err) $display("FAIL single_resp_error: got %b want %b", err, e.err); else n_pass++;
    n_checks++; if (f !== e.factor) $display("FAIL single_factor: got %h want %h", f, e.factor); else n_pass++;
    n_checks++; if (f[63:0] !== 64'h4014000000000000) $display("FAIL single_l00: got %h want 4014000000000000", f[63:0]); else n_pass++;
    n_checks++; if (f[575:512] !== 64'h4008000000000000) $display("FAIL single_l22: got %h want 4008000000000000", f[575:512]); else n_pass++;
    n_checks++; if (at_r - at_a !== EN_CYCLES + MODEL_LAT + 1) $display("FAIL single_latency: got %0d want %0d", at_r - at_a, EN_CYCLES + MODEL_LAT + 1); else n_pass++;
    n_checks++; if (en_hi !== EN_CYCLES) $display("FAIL single_enable_cycles: got %0d want %0d", en_hi, EN_CYCLES); else n_pass++;
  endtask

  task automatic test_contention();
    logic [1:0] set_v [5] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b11};
    logic [1:0] exp_g [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    logic [W-1:0] m0, m1, f;
    logic [1:0] acc, rv;
    logic err;
    int at_a, at_r;
    exp_t e;
    apply_reset();
    model_mode = 0;
    m0 = mat3(4, 2, 0, 2, 5, 0, 0, 0, 9);
    m1 = mat3(9, 3, 0, 3, 5, 2, 0, 2, 5);
    req_matrix0_i = m0; req_matrix1_i = m1;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      e.who = exp_g[j]; e.err = 1'b0; e.factor = chol_ref(exp_g[j][1] ? m1 : m0);
      sb.push_back(e);
      req_valid_i = set_v[j];
      wait_accept(acc, at_a);
      n_checks++; if (acc !== exp_g[j]) $display("FAIL contention_accept[%0d]: got %b want %b", j, acc, exp_g[j]); else n_pass++;
      @(posedge clk); #1 req_valid_i = 2'b00;
      wait_resp(rv, err, f, at_r);
      e = sb.pop_front();
      n_checks++; if (rv !== e.who) $display("FAIL contention_resp_valid[%0d]: got %b want %b", j, rv, e.who); else n_pass++;
      n_checks++; if (f !== e.factor || err !== e.err) $display("FAIL contention_factor[%0d]: got %h/%b want %h/%b", j, f, err, e.factor, e.err); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ma, mb, f;
    logic [1:0] acc, rv;
    logic err;
    int at_a, at_r;
    exp_t e;
    model_mode = 0;
    ma = mat3(16, 4, 8, 4, 5, 6, 8, 6, 30);
    mb = mat3(1, 0, 0, 0, 4, 0, 0, 0, 16);
    @(posedge clk); #1;
    req_matrix0_i = ma;
    e.who = 2'b01; e.err = 1'b0; e.factor = chol_ref(ma); sb.push_back(e);
    req_valid_i = 2'b01;
    wait_accept(acc, at_a);
    n_checks++; if (acc !== 2'b01) $display("FAIL b2b_accept0: got %b want 01", acc); else n_pass++;
    // Change the source matrix mid-job; the job in flight must be unaffected
    @(posedge clk); #1;
    req_matrix0_i = mb;
    e.factor = chol_ref(mb); sb.push_back(e);
    wait_resp(rv, err, f, at_r);
    e = sb.pop_front();
    n_checks++; if (rv !== e.who || err !== e.err || f !== e.factor) $display("FAIL b2b_resp0: got %b/%b/%h want %b/%b/%h", rv, err, f, e.who, e.err, e.factor); else n_pass++;
    wait_accept(acc, at_a);
    n_checks++; if (acc !== 2'b01) $display("FAIL b2b_accept1: got %b want 01", acc); else n_pass++;
    n_checks++; if (at_a !== at_r + 1) $display("FAIL b2b_gap: accept at %0d want %0d", at_a, at_r + 1); else n_pass++;
    @(posedge clk); #1 req_valid_i = 2'b00;
    wait_resp(rv, err, f, at_r);
    e = sb.pop_front();
    n_checks++; if (rv !== e.who || err !== e.err || f !== e.factor) $display("FAIL b2b_resp1: got %b/%b/%h want %b/%b/%h", rv, err, f, e.who, e.err, e.factor); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [W-1:0] f;
    logic [1:0] acc, rv;
    logic err;
    int at_a, at_r;
    exp_t e;
    model_mode = 1;
    @(posedge clk); #1;
    req_matrix1_i = mat3(4, 2, 0, 2, 5, 0, 0, 0, 9);
    e.who = 2'b10; e.err = 1'b1; e.factor = '0; sb.push_back(e);
    req_valid_i = 2'b10;
    wait_accept(acc, at_a);
    n_checks++; if (acc !== 2'b10) $display("FAIL timeout_accept: got %b want 10", acc); else n_pass++;
    @(posedge clk); #1 req_valid_i = 2'b00;
    wait_resp(rv, err, f, at_r);
    e = sb.pop_front();
    n_checks++; if (rv !== e.who) $display("FAIL timeout_resp_valid: got %b want %b", rv, e.who); else n_pass++;
    n_checks++; if (err !== e.err) $display("FAIL timeout_resp_error: got %b want %b", err, e.err); else n_pass++;
    n_checks++; if (f !== e.factor) $display("FAIL timeout_factor: got %h want 0", f); else n_pass++;
    n_checks++; if (at_r - at_a !== EN_CYCLES + TIMEOUT + 1) $display("FAIL timeout_latency: got %0d want %0d", at_r - at_a, EN_CYCLES + TIMEOUT + 1); else n_pass++;
  endtask

  task automatic test_stale_ready();
    logic [W-1:0] m, f;
    logic [1:0] acc, rv;
    logic err;
    int at_a, at_r;
    exp_t e;
    model_mode = 2;
    m = mat3(9, 3, 0, 3, 5, 2, 0, 2, 5);
    @(posedge clk); #1;
    chol_ready_i = 1'b1; chol_factor_i = chol_ref(m);
    req_matrix0_i = m;
    e.who = 2'b01; e.err = 1'b0; e.factor = chol_ref(m); sb.push_back(e);
    req_valid_i = 2'b01;
    wait_accept(acc, at_a);
    n_checks++; if (acc !== 2'b01) $display("FAIL stale_accept: got %b want 01", acc); else n_pass++;
    @(posedge clk); #1 req_valid_i = 2'b00;
    // Ready is still high when WAIT starts; drop it, then raise it 10 cycles in
    while (cyc < at_a + 7) begin @(posedge clk); #1; end
    chol_ready_i = 1'b0;
    while (cyc < at_a + 1 + EN_CYCLES + 9) begin @(posedge clk); #1; end
    chol_ready_i = 1'b1;
    wait_resp(rv, err, f, at_r);
    e = sb.pop_front();
    n_checks++; if (rv !== e.who || err !== e.err) $display("FAIL stale_resp: got %b/%b want %b/%b", rv, err, e.who, e.err); else n_pass++;
    n_checks++; if (f !== e.factor) $display("FAIL stale_factor: got %h want %h", f, e.factor); else n_pass++;
    n_checks++; if (at_r - at_a !== EN_CYCLES + 10 + 1) $display("FAIL stale_latency: got %0d want %0d", at_r - at_a, EN_CYCLES + 11); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    logic [W-1:0] m, f;
    logic [1:0] acc, rv;
    logic err;
    int at_a, at_r, n_resp;
    exp_t e;
    model_mode = 1;
    @(posedge clk); #1;
    req_matrix0_i = mat3(4, 2, 0, 2, 5, 0, 0, 0, 9);
    req_valid_i = 2'b01;
    wait_accept(acc, at_a);
    n_checks++; if (acc !== 2'b01) $display("FAIL rstwait_accept: got %b want 01", acc); else n_pass++;
    @(posedge clk); #1 req_valid_i = 2'b00;
    while (cyc < at_a + 7) begin @(posedge clk); #1; end
    n_checks++; if (busy_o !== 1'b1) $display("FAIL rstwait_busy_before: got %b want 1", busy_o); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) $display("FAIL rstwait_busy: got %b want 0", busy_o); else n_pass++;
    n_checks++; if (chol_enable_o !== 1'b0) $display("FAIL rstwait_enable: got %b want 0", chol_enable_o); else n_pass++;
    n_resp = 0;
    repeat (TIMEOUT + 14) begin
      @(negedge clk);
      if (resp_valid_o !== 2'b00) n_resp++;
    end
    n_checks++; if (n_resp !== 0) $display("FAIL rstwait_no_resp: got %0d responses want 0", n_resp); else n_pass++;
    model_mode = 0;
    m = mat3(16, 4, 8, 4, 5, 6, 8, 6, 30);
    @(posedge clk); #1;
    req_matrix1_i = m;
    e.who = 2'b10; e.err = 1'b0; e.factor = chol_ref(m); sb.push_back(e);
    req_valid_i = 2'b10;
    wait_accept(acc, at_a);
    n_checks++; if (acc !== 2'b10) $display("FAIL rstwait_accept1: got %b want 10", acc); else n_pass++;
    @(posedge clk); #1 req_valid_i = 2'b00;
    wait_resp(rv, err, f, at_r);
    e = sb.pop_front();
    n_checks++; if (rv !== e.who || err !== e.err || f !== e.factor) $display("FAIL rstwait_resp1: got %b/%b/%h want %b/%b/%h", rv, err, f, e.who, e.err, e.factor); else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    req_valid_i = 2'b00;
    req_matrix0_i = '0;
    req_matrix1_i = '0;
    chol_ready_i = 1'b0;
    chol_factor_i = '0;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_timeout();
    test_stale_ready();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule : tb_cholesky_scheduler
`default_nettype wire
